wb_uart_tx_cfg: RTL

// - Wishbone-fed UART transmitter with a TX queue and a runtime-configurable frame format.
// - Frame format is selectable per frame: 5-8 data bits, none/even/odd parity, 1 or 2 stop bits.
// - Sits on the peripheral bus beside the existing fixed 8N1 TX.
// - Reports queue fill level, busy state and a sticky overflow flag to the control/status register block.

---
 rtl/wb_uart_tx_cfg.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/wb_uart_tx_cfg.sv
// Wishbone-fed UART transmitter: TX queue, per-frame 5-8 data bits, parity, 1/2 stop.
// Define UART_TX_CTS_EN to add the cts_n flow-control input.
module wb_uart_tx_cfg #(
  parameter int BUFFER          = 32,
  parameter int PRESCALER_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       tx,
  input  logic [PRESCALER_WIDTH-1:0] prescaler,
  input  logic [1:0]                 data_bits,
  input  logic [1:0]                 parity,
  input  logic                       two_stop,
  input  logic                       clear,
  output logic [$clog2(BUFFER):0]    size,
  output logic                       busy,
  output logic                       overflow,
  input  logic [7:0]                 dat_i,
  input  logic                       we_i,
  input  logic                       stb_i,
  output logic                       ack_o
`ifdef UART_TX_CTS_EN
  ,
  input  logic                       cts_n
`endif
);

  localparam int AW = $clog2(BUFFER);
  localparam int PW = PRESCALER_WIDTH;
  localparam logic [AW:0] DEPTH = (AW+1)'(BUFFER);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  logic          ack_q;
  logic          push;
  logic          pop;
  logic          wr_ok;
  logic          ovf_set;
  logic          full;
  logic          empty;
  logic          avail;
  logic          cts_ok;
  logic [7:0]    mem [BUFFER];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [7:0]    rd;
  logic [7:0]    mask;

  state_t        state, state_d;
  logic [PW-1:0] cnt, cnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    nbits, nbits_d;
  logic [7:0]    sh, sh_d;
  logic          pbit, pbit_d;
  logic          pen_q, pen_d;
  logic          two_q, two_d;
  logic          stop2, stop2_d;
  logic          tx_d;
  logic          tick;

  assign ack_o   = stb_i & ack_q;
  assign push    = stb_i & we_i & ack_q;
  assign full    = (size == DEPTH);
  assign empty   = (size == '0);
  assign wr_ok   = push & ~clear & (~full | pop);
  assign ovf_set = push & ~clear & full & ~pop;
  assign busy    = (state != IDLE) | ~empty;
  assign rd      = mem[rp];
  assign mask    = 8'hFF >> (2'd3 - data_bits);
  assign tick    = (cnt == '0);
  assign avail   = ~empty & ~clear & cts_ok;

`ifdef UART_TX_CTS_EN
  logic [1:0] cts_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cts_sync <= 2'b11;
    else     cts_sync <= {cts_sync[0], cts_n};
  end

  assign cts_ok = ~cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= dat_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_q    <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      size     <= '0;
      overflow <= 1'b0;
    end else begin
      ack_q <= stb_i & we_i;
      if (clear) begin
        wp       <= '0;
        rp       <= '0;
        size     <= '0;
        overflow <= 1'b0;
      end else begin
        if (wr_ok) wp <= wp + AW'(1);
        if (pop)   rp <= rp + AW'(1);
        if (wr_ok & ~pop)      size <= size + (AW+1)'(1);
        else if (~wr_ok & pop) size <= size - (AW+1)'(1);
        if (ovf_set) overflow <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = tick ? pre_q : cnt - PW'(1);
    pre_d   = pre_q;
    nbits_d = nbits;
    sh_d    = sh;
    pbit_d  = pbit;
    pen_d   = pen_q;
    two_d   = two_q;
    stop2_d = stop2;
    tx_d    = tx;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        tx_d = 1'b1;
        pop  = avail;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = sh[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (nbits != 3'd0) begin
            nbits_d = nbits - 3'd1;
            sh_d    = {1'b0, sh[7:1]};
            tx_d    = sh[1];
          end else if (pen_q) begin
            state_d = PARITY;
            tx_d    = pbit;
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
            stop2_d = two_q;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
          stop2_d = two_q;
        end
      end
      STOP: begin
        if (tick) begin
          if (stop2)      stop2_d = 1'b0;
          else if (avail) pop     = 1'b1;
          else            state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // Frame format is captured together with the byte and held all frame.
    if (pop) begin
      state_d = START;
      cnt_d   = prescaler;
      pre_d   = prescaler;
      nbits_d = {1'b1, data_bits};
      sh_d    = rd;
      pbit_d  = ^(rd & mask) ^ parity[1];
      pen_d   = parity[0] ^ parity[1];
      two_d   = two_stop;
      stop2_d = 1'b0;
      tx_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pre_q <= '0;
      nbits <= '0;
      sh    <= '0;
      pbit  <= 1'b0;
      pen_q <= 1'b0;
      two_q <= 1'b0;
      stop2 <= 1'b0;
      tx    <= 1'b1;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      pre_q <= pre_d;
      nbits <= nbits_d;
      sh    <= sh_d;
      pbit  <= pbit_d;
      pen_q <= pen_d;
      two_q <= two_d;
      stop2 <= stop2_d;
      tx    <= tx_d;
    end
  end

endmodule
